// File: rtl/prog_clkdiv.sv
// prog_clkdiv: bank of independent programmable clock dividers.
// Each channel counts 0..A and wraps. Its divided clock is low for the first
// floor(R/2) cycles of a period and high for the rest (R = A+1). Its tick marks
// the last cycle of a period. Divisor writes are deferred to the next wrap
// unless the channel is already at a boundary, so the output never produces
// a runt pulse. A sync pulse realigns every channel to count 0 at once.
module prog_clkdiv #(
  parameter  int NCH   = 4,
  parameter  int DIV_W = 8,
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             sync,
  output logic [NCH-1:0]   div_o,
  output logic [NCH-1:0]   tick_o
);

  // Divisor a channel comes out of reset with: 2^(ch+1)-1, saturated to the
  // field width, so the channels start at ratios 2, 4, 8, 16, ...
  function automatic logic [DIV_W-1:0] rst_div(input int ch);
    logic [DIV_W-1:0] v;
    v = '0;
    for (int b = 0; b < DIV_W; b++) begin
      if (b <= ch) v[b] = 1'b1;
    end
    return v;
  endfunction

  // Pending-write flag of every channel, gathered for the ready mux.
  logic [NCH-1:0] pend_vec;
  logic           cfg_acc;

  // Ready reflects only the addressed channel's pending flag. Out-of-range
  // channels are always ready, so writes to them are swallowed.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (cfg_ch == CH_W'(i)) cfg_ready = !pend_vec[i];
    end
  end

  assign cfg_acc = cfg_valid && cfg_ready;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    localparam logic [DIV_W-1:0] RST_A = rst_div(gi);

    logic [DIV_W-1:0] a_q, a_d;
    logic [DIV_W-1:0] s_q, s_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             p_q, p_d;
    logic             div_q, div_d;
    logic             tick_q, tick_d;
    logic             wr_sel;
    logic             at_wrap;
    logic             stopped;
    logic [DIV_W:0]   half;

    assign wr_sel  = cfg_acc && (cfg_ch == CH_W'(gi));
    assign stopped = (a_q == '0);
    assign at_wrap = !stopped && (cnt_q == a_q);

    // Next divisor/counter state. The registered outputs are then derived from
    // that next state so they always match the counter they describe.
    always_comb begin
      a_d   = a_q;
      s_d   = s_q;
      p_d   = p_q;
      cnt_d = cnt_q;
      half  = '0;

      if (sync) begin
        // Realign: a write arriving now, or one still pending, takes effect here.
        cnt_d = '0;
        p_d   = 1'b0;
        if (wr_sel)   a_d = cfg_div;
        else if (p_q) a_d = s_q;
      end else if (wr_sel && (stopped || at_wrap)) begin
        // Already at a period boundary: apply immediately.
        a_d   = cfg_div;
        cnt_d = '0;
      end else if (wr_sel) begin
        // Mid-period: park the divisor until this period completes.
        s_d   = cfg_div;
        p_d   = 1'b1;
        cnt_d = cnt_q + DIV_W'(1);
      end else if (stopped) begin
        cnt_d = '0;
      end else if (at_wrap) begin
        cnt_d = '0;
        if (p_q) begin
          a_d = s_q;
          p_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end

      half   = ({1'b0, a_d} + (DIV_W + 1)'(1)) >> 1;
      div_d  = (a_d != '0) && ({1'b0, cnt_d} >= half);
      tick_d = (a_d != '0) && (cnt_d == a_d);
    end

    // Channel state registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        a_q    <= RST_A;
        s_q    <= '0;
        p_q    <= 1'b0;
        cnt_q  <= '0;
        div_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        a_q    <= a_d;
        s_q    <= s_d;
        p_q    <= p_d;
        cnt_q  <= cnt_d;
        div_q  <= div_d;
        tick_q <= tick_d;
      end
    end

    assign pend_vec[gi] = p_q;
    assign div_o[gi]    = div_q;
    assign tick_o[gi]   = tick_q;
  end

endmodule

// File: tb/tb_prog_clkdiv.sv
// Self-checking bench for prog_clkdiv: directed scenarios with literal
// expectations, then randomized writes/syncs/resets checked every cycle
// against a period/phase model of each channel.
module tb_prog_clkdiv;
  localparam int NCH   = 4;
  localparam int DIV_W = 8;
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic             sync;
  logic [NCH-1:0]   div_o;
  logic [NCH-1:0]   tick_o;

  int checks   = 0;
  int failures = 0;

  prog_clkdiv #(.NCH(NCH), .DIV_W(DIV_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .sync     (sync),
    .div_o    (div_o),
    .tick_o   (tick_o)
  );

  always #5 clk = ~clk;

  // Model: each channel is a period length (ratio, 1 = stopped), a position
  // inside the period, and an optional ratio waiting for the next boundary.
  int m_ratio [NCH];
  int m_pos   [NCH];
  int m_pend  [NCH];

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_ratio[c] = (c + 1 >= DIV_W) ? (1 << DIV_W) : (1 << (c + 1));
      m_pos[c]   = 0;
      m_pend[c]  = -1;
    end
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      model_reset();
    end else begin
      int  ch;
      bit  rdy;
      bit  w;
      bit  boundary;
      ch  = int'(cfg_ch);
      rdy = (ch >= NCH) ? 1'b1 : (m_pend[ch] < 0);
      for (int c = 0; c < NCH; c++) begin
        w        = cfg_valid && rdy && (ch == c);
        boundary = (m_ratio[c] == 1) || (m_pos[c] == m_ratio[c] - 1);
        if (sync) begin
          if (w)                m_ratio[c] = int'(cfg_div) + 1;
          else if (m_pend[c] >= 0) m_ratio[c] = m_pend[c];
          m_pend[c] = -1;
          m_pos[c]  = 0;
        end else if (w && boundary) begin
          m_ratio[c] = int'(cfg_div) + 1;
          m_pos[c]   = 0;
        end else if (w) begin
          m_pend[c] = int'(cfg_div) + 1;
          m_pos[c]  = m_pos[c] + 1;
        end else if (boundary) begin
          m_pos[c] = 0;
          if (m_pend[c] >= 0) begin
            m_ratio[c] = m_pend[c];
            m_pend[c]  = -1;
          end
        end else begin
          m_pos[c] = m_pos[c] + 1;
        end
      end
    end
  end

  // Compare DUT outputs against the model on every falling edge.
  always @(negedge clk) begin
    logic [NCH-1:0] e_div;
    logic [NCH-1:0] e_tick;
    logic           e_rdy;
    for (int c = 0; c < NCH; c++) begin
      e_div[c]  = (m_ratio[c] > 1) && (m_pos[c] >= m_ratio[c] / 2);
      e_tick[c] = (m_ratio[c] > 1) && (m_pos[c] == m_ratio[c] - 1);
    end
    e_rdy = (int'(cfg_ch) >= NCH) ? 1'b1 : (m_pend[int'(cfg_ch)] < 0);
    checks++;
    if (div_o !== e_div || tick_o !== e_tick || cfg_ready !== e_rdy) begin
      failures++;
      if (failures <= 20)
        $display("FAIL cycle t=%0t div_o=%b exp=%b tick_o=%b exp=%b cfg_ready=%b exp=%b",
                 $time, div_o, e_div, tick_o, e_tick, cfg_ready, e_rdy);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input int ch, input int v);
    cfg_valid = 1'b1;
    cfg_ch    = CH_W'(ch);
    cfg_div   = DIV_W'(v);
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_sync();
    sync = 1'b1;
    step();
    sync = 1'b0;
  endtask

  int a0, a1, a2;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_div   = '0;
    sync      = 1'b0;
    model_reset();

    // Reset state
    #1;
    check("reset_div_o", int'(div_o), 0);
    check("reset_tick_o", int'(tick_o), 0);
    check("reset_ready", int'(cfg_ready), 1);
    @(negedge clk);
    rst = 1'b1;

    // Defaults: ch0 period 2, ch3 low 8 / high 8, one ch3 tick per 16
    a0 = 0; a1 = 0; a2 = 0;
    repeat (32) begin
      step();
      a0 += int'(div_o[3]);
      a1 += int'(tick_o[3]);
      a2 += int'(tick_o[0]);
    end
    check("dflt_ch3_high", a0, 16);
    check("dflt_ch3_ticks", a1, 2);
    check("dflt_ch0_ticks", a2, 16);

    // Odd ratio 5 on ch1
    write(1, 4);
    repeat (12) step();
    a0 = 0; a1 = 0;
    repeat (10) begin
      step();
      a0 += int'(div_o[1]);
      a1 += int'(tick_o[1]);
    end
    check("odd_ch1_high", a0, 6);
    check("odd_ch1_ticks", a1, 2);

    // Deferred change on ch2 (A=7) written while cnt=3
    pulse_sync();
    repeat (3) step();
    write(2, 2);
    a0 = 0;
    repeat (8) begin
      a0 += int'(!cfg_ready);
      step();
    end
    check("defer_ready_low", a0, 4);
    a0 = 0; a1 = 0;
    repeat (6) begin
      step();
      a0 += int'(div_o[2]);
      a1 += int'(tick_o[2]);
    end
    check("defer_ch2_high", a0, 4);
    check("defer_ch2_ticks", a1, 2);

    // Stop ch0, then restart at ratio 2
    write(0, 0);
    repeat (4) step();
    a0 = 0;
    repeat (8) begin
      step();
      a0 += int'(div_o[0]) + int'(tick_o[0]);
    end
    check("stop_ch0_quiet", a0, 0);
    write(0, 1);
    check("start_ch0_div", int'(div_o[0]), 0);
    a0 = 0;
    repeat (8) begin
      step();
      a0 += int'(tick_o[0]);
    end
    check("start_ch0_ticks", a0, 4);

    // Sync with a pending write on ch0
    pulse_sync();
    write(0, 5);
    sync = 1'b1;
    check("sync_pre_ready", int'(cfg_ready), 0);
    step();
    sync = 1'b0;
    check("sync_div_o", int'(div_o), 0);
    check("sync_tick_o", int'(tick_o), 0);
    check("sync_ready", int'(cfg_ready), 1);
    a0 = 0;
    repeat (12) begin
      step();
      a0 += int'(tick_o[0]);
    end
    check("sync_ch0_ticks", a0, 2);

    // Async reset between edges with ch1 pending
    pulse_sync();
    write(1, 6);
    #2 rst = 1'b0;
    #1;
    check("arst_div_o", int'(div_o), 0);
    check("arst_tick_o", int'(tick_o), 0);
    check("arst_ready", int'(cfg_ready), 1);
    @(negedge clk);
    rst = 1'b1;
    step();
    check("arst_first_div", int'(div_o), 1);
    check("arst_first_tick", int'(tick_o), 1);
    a0 = int'(tick_o[1]);
    a1 = int'(div_o[1]);
    repeat (7) begin
      step();
      a0 += int'(tick_o[1]);
      a1 += int'(div_o[1]);
    end
    check("arst_ch1_ticks", a0, 2);
    check("arst_ch1_high", a1, 4);

    // Randomized traffic checked cycle by cycle against the model
    for (int n = 0; n < 3000; n++) begin
      cfg_valid = ($urandom % 3) == 0;
      cfg_ch    = CH_W'($urandom);
      cfg_div   = (($urandom % 50) == 0) ? DIV_W'($urandom) : DIV_W'($urandom_range(0, 10));
      sync      = ($urandom % 40) == 0;
      if (($urandom % 400) == 0) begin
        rst = 1'b0;
        #2 rst = 1'b1;
      end
      step();
    end
    cfg_valid = 1'b0;
    sync      = 1'b0;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_clkdiv.md
PROG_CLKDIV -- requirements
Module: prog_clkdiv

Interface
REQ-001 Parameter NCH, default 4: number of independent divider channels, 1..16.
REQ-002 Parameter DIV_W, default 8: width of the divisor field, 2..16.
REQ-003 Localparam CH_W = max(1, clog2(NCH)): width of the channel select.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 cfg_valid  in  1  config write request.
REQ-007 cfg_ready  out  1  config write can be accepted.
REQ-008 cfg_ch  in  CH_W  target channel of the config write.
REQ-009 cfg_div  in  DIV_W  divisor code V; ratio R = V+1; V=0 stops the channel.
REQ-010 sync  in  1  single-cycle phase-align request for all channels.
REQ-011 div_o  out  NCH  divided clock per channel, registered.
REQ-012 tick_o  out  NCH  one-cycle terminal-count strobe per channel, registered.

Function
REQ-013 Each channel i SHALL hold:
  - active divisor A[i] (DIV_W bits);
  - shadow divisor S[i];
  - pending flag P[i];
  - counter cnt[i] (DIV_W bits).
REQ-014 Running channel (A != 0): cnt SHALL count 0,1,...,A then wrap to 0, one step per clk.
REQ-015 Stopped channel (A == 0): cnt SHALL be held at 0.
REQ-016 div_o[i] SHALL equal (A != 0) && (cnt >= H), H = (A+1)>>1, in every cycle.
  - Result: low for floor(R/2) cycles, then high for ceil(R/2) cycles.
  - div_o SHALL be driven directly from a flop.
REQ-017 tick_o[i] SHALL equal (A != 0) && (cnt == A), driven from a flop.
  - Result: exactly one pulse per period, coincident with the last cycle of the period.
REQ-018 cfg_ready SHALL be !P[cfg_ch] when cfg_ch < NCH, and 1 otherwise.
  - cfg_ready is combinational from flops only; it SHALL NOT depend on cfg_valid.
REQ-019 A write SHALL be accepted on an edge where cfg_valid && cfg_ready; cfg_ch >= NCH SHALL be accepted and discarded.
REQ-020 On acceptance, cfg_div SHALL be applied as follows:
  - channel at terminal count (cnt == A) or stopped in that cycle: written to A at that edge; cnt wraps/stays at 0.
  - otherwise: written to S, and P set.
REQ-021 With P set, S SHALL be copied to A and P cleared on the edge where cnt == A (wrap edge). Counting SHALL restart from 0 with the new A.
REQ-022 Divisor changes SHALL take effect only at period boundaries, so div_o never emits a pulse shorter than min(old, new) half-period.
REQ-023 Writing V=0 to a running channel SHALL stop it at its next wrap, leaving cnt=0, div_o=0, tick_o=0.
REQ-024 sync=1 at an edge SHALL, for every channel:
  - apply any pending S to A and clear P;
  - load cnt=0.
  - sync SHALL take priority over normal counting and wrap.
REQ-025 A write accepted on the same edge as sync SHALL load A directly; cnt = 0.
REQ-026 Channels SHALL be fully independent apart from sync and the shared config port.

Reset
REQ-027 While rst=0, asynchronously and independent of clk, the block SHALL hold:
  - cnt=0, P=0, S=0;
  - div_o=0, tick_o=0;
  - A[i] = min(2^(i+1)-1, 2^DIV_W-1), giving ratios 2,4,8,16,... per channel.
REQ-028 On the first rising edge after rst deasserts, every channel SHALL leave cnt=0 and count normally. No config is required to start.
REQ-029 Reset asserted mid-period or with P set SHALL discard the pending write.

Verification
REQ-030 Reset defaults (NCH=4, DIV_W=8):
  - release rst -> div_o[0] period 2, div_o[3] low 8 / high 8;
  - tick_o[3] high exactly when cnt[3]=15, once per 16 cycles.
REQ-031 Odd ratio: write ch1 V=4 -> from the next wrap, div_o[1] low 2 / high 3, tick_o[1] once every 5 cycles.
REQ-032 Deferred change: ch2 at A=7, write V=2 while cnt=3:
  - cfg_ready low (cfg_ch=2) for 4 cycles;
  - old period completes intact, then period 3;
  - no runt pulse.
REQ-033 Stop/start:
  - write V=0 to ch0 -> after next wrap, div_o[0]=tick_o[0]=0 held;
  - write V=1 -> next cycle cnt=0, then period-2 output.
REQ-034 Sync with a pending write on ch0, channels at different phases, sync pulse:
  - next cycle all cnt=0, all div_o=0;
  - ch0 on its new divisor, P[0]=0.
REQ-035 Async reset mid-operation: assert rst between edges with P[1]=1:
  - outputs 0 before the next edge;
  - after release, ch1 runs at its default ratio 4.
